// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and default parameters for mem_sched_controller
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_MEM_WORDS   = 256;
  localparam int DEF_RD_LATENCY  = 2;
  localparam int DEF_WR_MAX_WAIT = 8;

  typedef enum logic {
    SCHED_NORMAL,
    SCHED_DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } rd_stage_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered circular FIFO with per-slot visibility for hazard checks
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH*WIDTH-1:0]   entries,
  output logic [DEPTH-1:0]         slot_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    offset;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    offset     = '0;
    entries    = '0;
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = AW'(i) - rd_ptr_q;
      slot_valid[i] = ({1'b0, offset} < count_q);
      entries[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

endmodule

// File: rtl/mem_sched_controller.sv
// rtl/mem_sched_controller.sv - queued single-port word memory with read-first/drain scheduler
module mem_sched_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int MEM_WORDS   = DEF_MEM_WORDS,
  parameter int RD_LATENCY  = DEF_RD_LATENCY,
  parameter int WR_MAX_WAIT = DEF_WR_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_ret_address,
  output logic              wr_ret_ack,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic              rd_en,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_ret_data,
  output logic [ADDR_W-1:0] rd_ret_address,
  output logic              rd_ret_ack
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(WR_MAX_WAIT + 1);
  localparam int QW    = $clog2(DEPTH);
  localparam int WE_W  = $bits(wr_entry_t);

  // Entry and stage structs are laid out with the package default widths.
  if (ADDR_W != DEF_ADDR_W || DATA_W != DEF_DATA_W) begin : g_width_check
    $error("ADDR_W/DATA_W must match the mem_ctrl_pkg entry layout");
  end

  wr_entry_t               wq_push_entry;
  wr_entry_t               wq_head;
  wr_entry_t               wq_slot;
  logic                    wq_push;
  logic                    wq_full;
  logic                    wq_empty;
  logic [QW:0]             wq_count;
  logic [QW:0]             wq_after_pop;
  logic [DEPTH*WE_W-1:0]   wq_entries;
  logic [DEPTH-1:0]        wq_valid;

  logic [ADDR_W-1:0]       rq_head;
  logic                    rq_push;
  logic                    rq_full;
  logic                    rq_empty;
  logic [QW:0]             rq_count;
  logic [DEPTH*ADDR_W-1:0] rq_entries;
  logic [DEPTH-1:0]        rq_valid;

  sched_state_t            state_q;
  sched_state_t            state_d;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic                    wait_expired;
  logic                    raw_hazard;
  logic                    drain_mode;
  logic                    issue_wr;
  logic                    issue_rd;

  logic [DATA_W-1:0]       mem [MEM_WORDS];
  rd_stage_t               stage_q [RD_LATENCY];
  rd_stage_t               rd_last;

  logic                    wr_ret_ack_q;
  logic [ADDR_W-1:0]       wr_ret_address_q;
  logic                    unused_fifo_bits;

  assign wq_push_entry = '{addr: wr_address, data: wr_data};
  assign wr_ready      = !wq_full;
  assign rd_ready      = !rq_full;
  assign wq_push       = wr_en && wr_ready;
  assign rq_push       = rd_en && rd_ready;

  sync_fifo #(.WIDTH(WE_W), .DEPTH(DEPTH)) u_wr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wq_push),
    .push_data  (wq_push_entry),
    .pop        (issue_wr),
    .head       (wq_head),
    .full       (wq_full),
    .empty      (wq_empty),
    .count      (wq_count),
    .entries    (wq_entries),
    .slot_valid (wq_valid)
  );

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_rd_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rq_push),
    .push_data  (rd_address),
    .pop        (issue_rd),
    .head       (rq_head),
    .full       (rq_full),
    .empty      (rq_empty),
    .count      (rq_count),
    .entries    (rq_entries),
    .slot_valid (rq_valid)
  );

  assign unused_fifo_bits = ^{rq_count, rq_entries, rq_valid, wq_entries};

  // Index-only compare: aliased addresses hit the same word, so they are hazards too.
  always_comb begin
    raw_hazard = 1'b0;
    wq_slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wq_slot = wq_entries[i*WE_W +: WE_W];
      if (wq_valid[i] && !rq_empty &&
          (wq_slot.addr[IDX_W-1:0] == rq_head[IDX_W-1:0])) begin
        raw_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SCHED_NORMAL;
    else       state_q <= state_d;
  end

  // Drain entry is decided before issue so the triggering cycle already issues a write.
  always_comb begin
    wait_expired = (wait_cnt_q == CNT_W'(WR_MAX_WAIT));
    drain_mode   = (state_q == SCHED_DRAIN) || wq_full || raw_hazard || wait_expired;
    issue_wr     = 1'b0;
    issue_rd     = 1'b0;
    if (drain_mode)     issue_wr = !wq_empty;
    else if (!rq_empty) issue_rd = 1'b1;
    else                issue_wr = !wq_empty;
    wq_after_pop = wq_count - (QW+1)'(issue_wr);
    state_d      = SCHED_NORMAL;
    if (drain_mode && (wq_push || (wq_after_pop != '0))) state_d = SCHED_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (reset)                     wait_cnt_q <= '0;
    else if (issue_wr || wq_empty) wait_cnt_q <= '0;
    else if (!wait_expired)        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (issue_wr) mem[wq_head.addr[IDX_W-1:0]] <= wq_head.data;
  end

  // Stage 0 samples the array at issue, so a write one cycle earlier is already visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: issue_rd,
                      addr:  issue_rd ? rq_head : '0,
                      data:  issue_rd ? mem[rq_head[IDX_W-1:0]] : '0};
      for (int i = 1; i < RD_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ret_ack_q     <= 1'b0;
      wr_ret_address_q <= '0;
    end else begin
      wr_ret_ack_q <= issue_wr;
      if (issue_wr) wr_ret_address_q <= wq_head.addr;
    end
  end

  assign rd_last        = stage_q[RD_LATENCY-1];
  assign rd_ret_ack     = rd_last.valid;
  assign rd_ret_data    = rd_last.data;
  assign rd_ret_address = rd_last.addr;
  assign wr_ret_ack     = wr_ret_ack_q;
  assign wr_ret_address = wr_ret_address_q;

endmodule

// File: tb/tb_mem_sched_controller.sv
// tb/tb_mem_sched_controller.sv - directed self-checking bench for mem_sched_controller
module tb_mem_sched_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wr_address;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [15:0] wr_ret_address;
  logic        wr_ret_ack;
  logic [15:0] rd_address;
  logic        rd_en;
  logic        rd_ready;
  logic [15:0] rd_ret_data;
  logic [15:0] rd_ret_address;
  logic        rd_ret_ack;

  int n_checks = 0;
  int n_fail   = 0;

  bit          t5_wa [0:10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
  logic [15:0] t5_wt [0:10] = '{0, 0, 0, 0, 16'h40, 16'h41, 16'h42, 16'h43, 16'h44, 0, 0};
  bit          t5_ra [0:10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
  logic [15:0] t5_rt [0:10] = '{0, 0, 16'h80, 16'h81, 16'h82, 0, 0, 0, 0, 0, 16'h83};
  bit          t5_ry [0:10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

  mem_sched_controller dut (
    .clk            (clk),
    .reset          (reset),
    .wr_address     (wr_address),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .wr_ret_address (wr_ret_address),
    .wr_ret_ack     (wr_ret_ack),
    .rd_address     (rd_address),
    .rd_en          (rd_en),
    .rd_ready       (rd_ready),
    .rd_ret_data    (rd_ret_data),
    .rd_ret_address (rd_ret_address),
    .rd_ret_ack     (rd_ret_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_acks(input string tag, input logic wa, input logic [15:0] wt,
                             input logic ra, input logic [15:0] rt);
    check({tag, ".wr_ack"}, wr_ret_ack, wa);
    if (wa) check({tag, ".wr_tag"}, wr_ret_address, wt);
    check({tag, ".rd_ack"}, rd_ret_ack, ra);
    if (ra) check({tag, ".rd_tag"}, rd_ret_address, rt);
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] d);
    rd_en = 1'b1; rd_address = a;
    step();
    rd_en = 1'b0;
    step();
    check({tag, ".early"}, rd_ret_ack, 1'b0);
    step();
    check({tag, ".ack"}, rd_ret_ack, 1'b1);
    check({tag, ".tag"}, rd_ret_address, a);
    check({tag, ".data"}, rd_ret_data, d);
  endtask

  task automatic raw_case(input string tag, input logic [15:0] wa, input logic [15:0] wd,
                          input logic [15:0] ra);
    wr_en = 1'b1; wr_address = wa; wr_data = wd;
    rd_en = 1'b1; rd_address = ra;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    expect_acks({tag, ".e0"}, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    expect_acks({tag, ".e1"}, 1'b1, wa, 1'b0, 16'h0);
    step();
    expect_acks({tag, ".e2"}, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    expect_acks({tag, ".e3"}, 1'b0, 16'h0, 1'b1, ra);
    check({tag, ".data"}, rd_ret_data, wd);
    step();
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_address = '0; wr_data = '0;
    rd_en = 1'b0; rd_address = '0;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst.wr_ready%0d", k), wr_ready, 1'b1);
      check($sformatf("rst.rd_ready%0d", k), rd_ready, 1'b1);
      check($sformatf("rst.outs%0d", k),
            {wr_ret_ack, rd_ret_ack, wr_ret_address, rd_ret_address, rd_ret_data}, '0);
      step();
    end

    // single write then read, minimum latencies
    wr_en = 1'b1; wr_address = 16'h0010; wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    expect_acks("t2.e0", 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    expect_acks("t2.e1", 1'b1, 16'h0010, 1'b0, 16'h0);
    step();
    expect_acks("t2.e2", 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    rd_en = 1'b1; rd_address = 16'h0010;
    step();
    rd_en = 1'b0;
    expect_acks("t2.e4", 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    expect_acks("t2.e5", 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    expect_acks("t2.e6", 1'b0, 16'h0, 1'b1, 16'h0010);
    check("t2.data", rd_ret_data, 16'hBEEF);
    step();
    expect_acks("t2.e7", 1'b0, 16'h0, 1'b0, 16'h0);

    raw_case("t3.raw", 16'h0020, 16'h1234, 16'h0020);
    raw_case("t4.alias", 16'h0105, 16'hAAAA, 16'h0005);

    // backpressure: full write queue forces a drain
    wr_en = 1'b1; wr_address = 16'h40; wr_data = 16'h5000;
    rd_en = 1'b1; rd_address = 16'h80;
    for (int k = 0; k <= 10; k++) begin
      step();
      expect_acks($sformatf("t5.e%0d", k), t5_wa[k], t5_wt[k], t5_ra[k], t5_rt[k]);
      if (k <= 5) check($sformatf("t5.wr_ready%0d", k), wr_ready, t5_ry[k]);
      if (k < 3) begin
        wr_address = 16'(16'h41 + k); wr_data = 16'(16'h5001 + k);
        rd_address = 16'(16'h81 + k);
      end else if (k == 3) begin
        wr_address = 16'h44; wr_data = 16'h5004;
        rd_en = 1'b0;
      end else if (k == 5) begin
        wr_en = 1'b0;
      end
    end
    read_check("t5.rb44", 16'h44, 16'h5004);
    read_check("t5.rb40", 16'h40, 16'h5000);

    // starvation: one write behind a stream of reads
    wr_en = 1'b1; wr_address = 16'h60; wr_data = 16'h6060;
    rd_en = 1'b1; rd_address = 16'hA0;
    for (int k = 0; k <= 12; k++) begin
      logic        ra;
      logic [15:0] rt;
      step();
      ra = ((k >= 2) && (k <= 9)) || (k == 11) || (k == 12);
      rt = (k <= 9) ? 16'(16'hA0 + k - 2) : 16'(16'hA8 + k - 11);
      expect_acks($sformatf("t6.e%0d", k), k == 9, 16'h60, ra, rt);
      if (k == 0) wr_en = 1'b0;
      if (k < 9) rd_address = 16'(16'hA1 + k);
      else       rd_en = 1'b0;
    end
    read_check("t6.rb60", 16'h60, 16'h6060);

    // reset with reads accepted but not yet returned
    rd_en = 1'b1; rd_address = 16'hB0;
    step();
    rd_address = 16'hB1;
    step();
    rd_en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7.rd_data", rd_ret_data, 16'h0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t7.rd_ack%0d", k), rd_ret_ack, 1'b0);
      check($sformatf("t7.ready%0d", k), {wr_ready, rd_ready}, 2'b11);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sched_controller.md
# mem_sched_controller

Synthesisable, parametrised successor to the simulation-only memory controller. It replaces the PLI-backed request/return model with an on-chip word memory fronted by separate read and write request queues. A two-mode scheduler issues one operation per cycle, keeps reads coherent with queued writes, and returns tagged acknowledgements on the same return channels the memory-simulator harness already consumes.

## Interface
- ADDR_W, 16, request/return address width
- DATA_W, 16, data word width
- DEPTH, 4, entries per request queue; power of two, ≥2
- MEM_WORDS, 256, memory words; power of two; indexed by address bits [log2(MEM_WORDS)-1:0]
- RD_LATENCY, 2, read pipeline stages; ≥1
- WR_MAX_WAIT, 8, cycles a non-empty write queue may wait before a forced drain

- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- wr_address  in  ADDR_W  write address
- wr_en  in  1  write request; accepted when wr_en && wr_ready
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write queue not full
- wr_ret_address  out  ADDR_W  tag (address) of completed write
- wr_ret_ack  out  1  one-cycle pulse per completed write
- rd_address  in  ADDR_W  read address
- rd_en  in  1  read request; accepted when rd_en && rd_ready
- rd_ready  out  1  read queue not full
- rd_ret_data  out  DATA_W  read data
- rd_ret_address  out  ADDR_W  tag (address) of returned read
- rd_ret_ack  out  1  one-cycle pulse per returned read

## Operation
- Two FIFOs of DEPTH entries: write queue {address, data}; read queue {address}.
- A request presented while its ready signal is low is ignored, with no side effect.
- At most one operation is issued per cycle; the memory is single-ported.
- Scheduler states:
  - NORMAL: issue the read-queue head if the read queue is non-empty; otherwise issue the write-queue head if non-empty; otherwise idle.
  - NORMAL→DRAIN, evaluated before issue in the same cycle, if any of the following holds:
    - the write queue is full;
    - the read head's index bits match any valid write-queue entry (RAW hazard);
    - the write wait counter equals WR_MAX_WAIT.
  - DRAIN: issue only writes, in FIFO order, until the write queue is empty.
  - DRAIN→NORMAL in the cycle after the last write issues.
- Write wait counter:
  - clears whenever a write issues or the write queue is empty;
  - otherwise increments each cycle and saturates at WR_MAX_WAIT.
- Hazard compare uses the index bits only, so aliased addresses count as hazards.
- Reads and writes each complete in issue order; returned tags are the full ADDR_W address.
- Memory contents are not reset. Reading a never-written word returns undefined data.
- Reset behaviour:
  - empties both queues and clears the wait counter;
  - returns the scheduler to NORMAL;
  - clears read-pipeline valids, so in-flight reads are dropped and never acknowledged;
  - drives all outputs to 0 except wr_ready = rd_ready = 1.

## Timing
- Acceptance edge = edge 0. The earliest issue is at edge 1, because the queues are registered with no bypass.
- Write issued at edge N: memory is updated at edge N. wr_ret_ack = 1, with wr_ret_address = tag, during the cycle after edge N.
- Read issued at edge N: rd_ret_ack = 1, with data and tag, during the cycle after edge N+RD_LATENCY-1.
- Minimum read latency, idle queues: accept edge 0 → rd_ret_ack after edge RD_LATENCY.
- A read issued the cycle after a write to the same index returns the new data.
- Ready signals are combinational from the queue counts:
  - ready is low while the queue is full;
  - a pop at edge N raises ready for the cycle after edge N.
- Push and pop on the same queue at the same edge: count is unchanged and both take effect.
- Sustained throughput is one operation per cycle. Both ack outputs may pulse in the same cycle.

## Structure
- Shared package mem_ctrl_pkg holds:
  - the scheduler state enum {SCHED_NORMAL, SCHED_DRAIN};
  - the write-entry and read-pipeline-stage struct typedefs;
  - default parameter constants.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count, with flattened entry visibility for the hazard compare) is instantiated twice.
- The memory array, scheduler, wait counter and read pipeline live in mem_sched_controller.

## Test plan
- Reset, then idle: all outputs 0 except wr_ready = rd_ready = 1. No ack ever pulses.
- Write 0x0010 = 0xBEEF at edge 0, then read 0x0010 at edge 4 with RD_LATENCY=2 → wr_ret_ack with tag 0x0010 after edge 1; rd_ret_ack with 0xBEEF and tag 0x0010 after edge 6.
- RAW hazard: in one cycle, queue write 0x0020 = 0x1234 and read 0x0020 → scheduler enters DRAIN, the write issues first, and the read returns 0x1234.
- Aliasing: MEM_WORDS=256, write 0x0105 = 0xAAAA, read 0x0005 → treated as a hazard; data 0xAAAA is returned with tag 0x0005.
- Backpressure: 5 writes on consecutive cycles while reads keep the scheduler busy → wr_ready low once 4 entries are queued; the 5th request is ignored until ready rises. Full queue forces DRAIN and all 4 acks arrive in order.
- Starvation: 1 queued write plus 10 back-to-back reads to other addresses, WR_MAX_WAIT=8 → the write issues no later than 9 cycles after reaching the queue head. Reset asserted with 2 reads in flight → no rd_ret_ack follows.
